// File: rtl/seq_mult_if.sv
// Operand/result bundle for seq_mult: request side (start/stop/operands) and status/result side.
interface seq_mult_if #(
    parameter int WIDTH = 6
);
    logic                   start;
    logic                   stop;
    logic [WIDTH-1:0]       in1;
    logic [WIDTH-1:0]       in2;
    logic                   busy;
    logic                   Done;
    logic [2*WIDTH-1:0]     mult_out;

    modport master (
        output start, stop, in1, in2,
        input  busy, Done, mult_out
    );

    modport slave (
        input  start, stop, in1, in2,
        output busy, Done, mult_out
    );
endinterface

// File: rtl/seq_mult.sv
// Shift-and-add unsigned multiplier, one multiplier bit per cycle; build option SEQ_MULT_EARLY_EXIT_EN.
// Purpose: WIDTH x WIDTH -> 2*WIDTH product from a start pulse, abortable with stop.
// Latency: WIDTH edges from accept to Done (early-exit build: up to the highest set bit of in2, min 1).
// Backpressure: none; start is ignored while busy, caller must wait for busy to drop.
module seq_mult #(
    parameter int WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_mult_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_nxt;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             last;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Finish as soon as no set multiplier bits remain above the one being consumed.
    assign last = (mplier[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
`else
    assign last = (cnt == CW'(WIDTH - 1));
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN: begin
                if (bus.stop)  state_nxt = IDLE;
                else if (last) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            prod   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.in1};
                        mplier <= bus.in2;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // An aborted iteration leaves the product register untouched.
                    if (!bus.stop) begin
                        acc    <= acc_nxt;
                        mplier <= mplier >> 1;
                        mcand  <= mcand << 1;
                        cnt    <= cnt + CW'(1);
                        if (last) prod <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.Done     = (state == FIN);
    assign bus.mult_out = prod;
endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: WIDTH=6 and WIDTH=16 instances checked against a plain arithmetic model.
module tb_seq_mult;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    seq_mult_if #(.WIDTH(6))  b6();
    seq_mult_if #(.WIDTH(16)) b16();

    seq_mult #(.WIDTH(6))  dut6  (.clk(clk), .rst_n(rst_n), .bus(b6));
    seq_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected number of edges from accept to Done.
    function automatic int exp_lat(input int w, input logic [31:0] b);
        int h;
        h = 0;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        for (int i = 0; i < w; i++) if (b[i]) h = i + 1;
        if (h < 1) h = 1;
`else
        h = w + 0 * int'(b[0]);
`endif
        return h;
    endfunction

    task automatic op6(input logic [5:0] a, input logic [5:0] b, input string nm);
        int          k;
        int          nb;
        int          lat;
        logic        held;
        logic [11:0] prev;
        lat  = exp_lat(6, {26'd0, b});
        prev = b6.mult_out;
        held = 1'b1;
        k    = 0;
        nb   = 0;
        b6.in1 = a; b6.in2 = b; b6.start = 1'b1;
        @(posedge clk); #1;
        b6.start = 1'b0;
        b6.in1 = 6'($urandom);
        b6.in2 = 6'($urandom);
        if (b6.busy === 1'b1) nb++;
        for (int i = 1; i <= 9 && k == 0; i++) begin
            @(posedge clk); #1;
            if (b6.busy === 1'b1) nb++;
            if (b6.Done === 1'b1) k = i;
            else if (b6.mult_out !== prev) held = 1'b0;
        end
        n_cmp++;
        if (k != lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, k, lat); end
        n_cmp++;
        if (b6.mult_out !== 12'(a) * 12'(b)) begin
            n_bad++; $display("FAIL %s product: got %0d want %0d", nm, b6.mult_out, 12'(a) * 12'(b));
        end
        n_cmp++;
        if (!held) begin n_bad++; $display("FAIL %s held_during_run: got changed want %0d", nm, prev); end
        n_cmp++;
        if (nb != lat + 1) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, nb, lat + 1); end
        @(posedge clk); #1;
        n_cmp++;
        if (b6.Done !== 1'b0 || b6.busy !== 1'b0) begin
            n_bad++; $display("FAIL %s after_fin: got done=%b busy=%b want 0 0", nm, b6.Done, b6.busy);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (b6.busy !== 1'b0 || b6.Done !== 1'b0 || b6.mult_out !== 12'd0) begin
            n_bad++; $display("FAIL reset6: got busy=%b done=%b out=%0d want 0 0 0", b6.busy, b6.Done, b6.mult_out);
        end
        n_cmp++;
        if (b16.busy !== 1'b0 || b16.Done !== 1'b0 || b16.mult_out !== 32'd0) begin
            n_bad++; $display("FAIL reset16: got busy=%b done=%b out=%0d want 0 0 0", b16.busy, b16.Done, b16.mult_out);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_corners();
        op6(6'd63, 6'd63, "max");
        op6(6'd45, 6'd0,  "zero_mult");
        op6(6'd5,  6'd4,  "five_four");
        op6(6'd0,  6'd33, "zero_mcand");
        op6(6'd1,  6'd32, "top_bit");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) op6(6'($urandom), 6'($urandom), "random");
    endtask

    task automatic test_stop();
        logic seen;
        int   k;
        op6(6'd7, 6'd9, "seven_nine");
        b6.in1 = 6'd10; b6.in2 = 6'd10; b6.start = 1'b1;
        @(posedge clk); #1; b6.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b6.stop = 1'b1;
        @(posedge clk); #1;
        b6.stop = 1'b0;
        n_cmp++;
        if (b6.busy !== 1'b0 || b6.Done !== 1'b0 || b6.mult_out !== 12'd63) begin
            n_bad++; $display("FAIL stop_abort: got busy=%b done=%b out=%0d want 0 0 63", b6.busy, b6.Done, b6.mult_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; if (b6.Done === 1'b1) seen = 1'b1; end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL stop_no_done: got done pulse want none"); end
        op6(6'd3, 6'd5, "after_stop");
        // stop in IDLE together with start must not block the start
        b6.in1 = 6'd6; b6.in2 = 6'd7; b6.start = 1'b1; b6.stop = 1'b1;
        @(posedge clk); #1; b6.start = 1'b0; b6.stop = 1'b0;
        n_cmp++;
        if (b6.busy !== 1'b1) begin n_bad++; $display("FAIL start_with_stop: got busy=%b want 1", b6.busy); end
        k = 0;
        for (int i = 1; i <= 9 && k == 0; i++) begin @(posedge clk); #1; if (b6.Done === 1'b1) k = i; end
        n_cmp++;
        if (k != exp_lat(6, 32'd7) || b6.mult_out !== 12'd42) begin
            n_bad++; $display("FAIL start_with_stop_result: got lat=%0d out=%0d want %0d 42", k, b6.mult_out, exp_lat(6, 32'd7));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_and_reset();
        int   k;
        logic seen;
        b6.in1 = 6'd12; b6.in2 = 6'd11; b6.start = 1'b1;
        @(posedge clk); #1; b6.start = 1'b0;
        @(posedge clk); #1;
        b6.in1 = 6'd1; b6.in2 = 6'd1; b6.start = 1'b1;
        @(posedge clk); #1; b6.start = 1'b0;
        k = 2;
        while (k < 9 && b6.Done !== 1'b1) begin @(posedge clk); #1; k++; end
        n_cmp++;
        if (k != exp_lat(6, 32'd11) || b6.mult_out !== 12'd132) begin
            n_bad++; $display("FAIL ignore_start: got lat=%0d out=%0d want %0d 132", k, b6.mult_out, exp_lat(6, 32'd11));
        end
        @(posedge clk); #1;
        b6.in1 = 6'd12; b6.in2 = 6'd11; b6.start = 1'b1;
        @(posedge clk); #1; b6.start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_cmp++;
        if (b6.busy !== 1'b0 || b6.Done !== 1'b0 || b6.mult_out !== 12'd0) begin
            n_bad++; $display("FAIL async_reset: got busy=%b done=%b out=%0d want 0 0 0", b6.busy, b6.Done, b6.mult_out);
        end
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; if (b6.Done === 1'b1 || b6.busy === 1'b1) seen = 1'b1; end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL reset_discard: got activity after reset want none"); end
        op6(6'($urandom), 6'($urandom), "first_after_reset");
    endtask

    task automatic test_back_to_back();
        int          k;
        logic        held;
        logic [15:0] a2;
        logic [15:0] b2;
        a2 = 16'($urandom);
        b2 = 16'($urandom);
        b16.in1 = 16'hFFFF; b16.in2 = 16'hFFFF; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.in1 = a2; b16.in2 = b2;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin @(posedge clk); #1; if (b16.Done === 1'b1) k = i; end
        n_cmp++;
        if (k != 16 || b16.mult_out !== 32'd4294836225) begin
            n_bad++; $display("FAIL w16_max: got lat=%0d out=%0d want 16 4294836225", k, b16.mult_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (b16.busy !== 1'b0 || b16.Done !== 1'b0) begin
            n_bad++; $display("FAIL w16_fin_ignores_start: got busy=%b done=%b want 0 0", b16.busy, b16.Done);
        end
        @(posedge clk); #1;
        b16.start = 1'b0;
        n_cmp++;
        if (b16.busy !== 1'b1) begin n_bad++; $display("FAIL w16_restart: got busy=%b want 1", b16.busy); end
        held = 1'b1;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(posedge clk); #1;
            if (b16.Done === 1'b1) k = i;
            else if (b16.mult_out !== 32'd4294836225) held = 1'b0;
        end
        n_cmp++;
        if (k != exp_lat(16, {16'd0, b2}) || b16.mult_out !== 32'(a2) * 32'(b2) || !held) begin
            n_bad++; $display("FAIL w16_second: got lat=%0d out=%0d held=%b want %0d %0d 1",
                              k, b16.mult_out, held, exp_lat(16, {16'd0, b2}), 32'(a2) * 32'(b2));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        b6.start = 1'b0;  b6.stop = 1'b0;  b6.in1 = '0;  b6.in2 = '0;
        b16.start = 1'b0; b16.stop = 1'b0; b16.in1 = '0; b16.in2 = '0;
        test_reset();
        test_corners();
        test_random();
        test_stop();
        test_ignore_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled on the rising clk edge.
REQ-005 SHALL have port stop  input  1  synchronous abort of an operation in progress.
REQ-006 SHALL have port in1  input  WIDTH  multiplicand, unsigned.
REQ-007 SHALL have port in2  input  WIDTH  multiplier, unsigned.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port Done  output  1  one-cycle pulse marking a valid new result.
REQ-010 SHALL have port mult_out  output  2*WIDTH  registered unsigned product.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, FIN.
REQ-012 IDLE: start=1 at an edge (E0) SHALL capture in1/in2 into internal registers, clear the accumulator and iteration counter, and enter RUN; in1/in2 are don't-care after E0.
REQ-013 RUN: each edge SHALL process one multiplier bit, LSB first: if bit=1, add the shifted multiplicand to the 2*WIDTH accumulator (no overflow is possible); then shift the multiplier right and the multiplicand left.
REQ-014 RUN SHALL perform exactly WIDTH iterations, at edges E1..E_WIDTH. At E_WIDTH it SHALL load mult_out with the final accumulator, set Done=1 and enter FIN.
REQ-015 FIN SHALL last one cycle: the next edge clears Done and returns to IDLE. A start seen in FIN SHALL be ignored.
REQ-016 busy SHALL equal (state != IDLE).
REQ-017 Done SHALL be high for exactly one cycle per completed operation.
REQ-018 mult_out SHALL hold its value from one completion until the next completion; it SHALL NOT change during RUN.
REQ-019 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-020 stop=1 in RUN SHALL return the FSM to IDLE at that edge, with Done staying 0 and mult_out unchanged.
REQ-021 stop SHALL take priority over completion at edge E_WIDTH.
REQ-022 stop in IDLE or FIN SHALL have no effect.
REQ-023 In IDLE, start=1 and stop=1 at the same edge SHALL start the operation; stop is ignored outside RUN.
REQ-024 Back-to-back operations: start may be asserted in the cycle after Done; the minimum period is WIDTH+2 cycles.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, Done=0, mult_out=0, and clear all internal operand, accumulator and counter registers.
REQ-026 Reset during RUN SHALL discard the operation, with no Done pulse.
REQ-027 After rst_n rises, the first start SHALL be accepted at the first rising edge on which start=1.

Configuration
REQ-028 Macro SEQ_MULT_EARLY_EXIT_EN, when defined, SHALL end RUN at the first iteration edge after which the remaining multiplier bits are all zero. At that edge: load mult_out, assert Done, enter FIN.
REQ-029 With SEQ_MULT_EARLY_EXIT_EN defined, latency from E0 to Done = max(1, index of the highest set bit of in2 + 1) edges. in2=0 SHALL complete at E1 with mult_out=0.
REQ-030 Without SEQ_MULT_EARLY_EXIT_EN, latency SHALL be fixed at WIDTH edges for every operand value. The ports and the product value are identical in both builds.

Verification
REQ-031 WIDTH=6, in1=63, in2=63, start pulse -> busy high for 7 cycles, Done pulse 6 edges after E0, mult_out=3969 held afterwards.
REQ-032 WIDTH=6, in1=45, in2=0 -> mult_out=0. Done at E6 without the macro; Done at E1 with SEQ_MULT_EARLY_EXIT_EN.
REQ-033 WIDTH=6, in1=5, in2=4 with SEQ_MULT_EARLY_EXIT_EN -> Done at E3, mult_out=20. Without the macro -> Done at E6, mult_out=20.
REQ-034 Complete 7*9=63, then start 10*10 and raise stop at E3 -> no Done, busy drops, mult_out stays 63. A new start then works normally.
REQ-035 Start 12*11, pulse start again at E2 with in1=1, in2=1, then drop rst_n at E4 -> second start ignored; on reset all outputs are 0 immediately (asynchronous) and no Done follows.
REQ-036 WIDTH=16, in1=in2=65535 -> mult_out=4294836225 after 16 iterations; check Done period and back-to-back restart.
